// File: rtl/victim_cache_param_pkg.sv
// Shared types for the victim cache: request opcodes and controller states.
package vc_pkg;

  typedef enum logic {
    VC_LOOKUP = 1'b0,
    VC_INSERT = 1'b1
  } vc_op_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    RESP      = 2'd3
  } vc_state_e;

endpackage

// File: rtl/victim_cache_param_if.sv
// L2-side request/response bus plus the memory writeback channel of the victim cache.
interface victim_cache_param_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 128
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_op;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_dirty;
  logic                  resp_valid;
  logic                  resp_hit;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_dirty;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_address;
  logic [DATA_WIDTH-1:0] wb_data;

  modport master (
    output req_valid, req_op, req_address, req_data, req_dirty, wb_ready,
    input  req_ready, resp_valid, resp_hit, resp_data, resp_dirty,
           wb_valid, wb_address, wb_data
  );

  modport slave (
    input  req_valid, req_op, req_address, req_data, req_dirty, wb_ready,
    output req_ready, resp_valid, resp_hit, resp_data, resp_dirty,
           wb_valid, wb_address, wb_data
  );
endinterface

// File: rtl/victim_cache_param_age_lru.sv
// True-LRU tracker: one age per way, ages always a permutation of 0..NUM_WAYS-1.
module vc_age_lru #(
  parameter int NUM_WAYS = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      touch,
  input  logic [$clog2(NUM_WAYS)-1:0]               touch_way,
  output logic [$clog2(NUM_WAYS)-1:0]               lru_way,
  output logic [NUM_WAYS-1:0][$clog2(NUM_WAYS)-1:0] age
);
  localparam int AW = $clog2(NUM_WAYS);

  // Only ways younger than the touched one age by one, so the set never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WAYS; i++) age[i] <= AW'(i);
    end else if (touch) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (AW'(i) == touch_way)        age[i] <= '0;
        else if (age[i] < age[touch_way]) age[i] <= age[i] + 1'b1;
      end
    end
  end

  always_comb begin
    lru_way = '0;
    for (int i = 0; i < NUM_WAYS; i++)
      if (age[i] == AW'(NUM_WAYS - 1)) lru_way = AW'(i);
  end
endmodule

// File: rtl/victim_cache_param.sv
// Fully-associative victim cache between L2 and memory: exclusive lookups, LRU
// replacement and dirty-victim writeback over a valid/ready channel.
module victim_cache_param
  import vc_pkg::*;
#(
  parameter int NUM_WAYS   = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 128
) (
  input logic           clk,
  input logic           rst,
  victim_cache_param_if.slave bus
);
  localparam int AW = $clog2(NUM_WAYS);

  vc_state_e state, state_nxt;

  vc_op_e                  op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    dirty_q;
  logic [AW-1:0]           tgt_q;

  logic [NUM_WAYS-1:0][ADDR_WIDTH-1:0] tags;
  logic [NUM_WAYS-1:0][DATA_WIDTH-1:0] lines;
  logic [NUM_WAYS-1:0]                 valid;
  logic [NUM_WAYS-1:0]                 dirty;

  logic                  resp_hit_q, resp_dirty_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic [ADDR_WIDTH-1:0] wb_addr_q;
  logic [DATA_WIDTH-1:0] wb_data_q;

  logic [NUM_WAYS-1:0] match;
  logic [AW-1:0]       hit_way, inv_way, lru_way, target, fill_way, touch_way;
  logic                any_hit, any_inv, tgt_dirty;
  logic                touch, fill, merge, take_hit, to_wb;
  logic [NUM_WAYS-1:0][AW-1:0] age;

  vc_age_lru #(.NUM_WAYS(NUM_WAYS)) u_lru (
    .clk       (clk),
    .rst       (rst),
    .touch     (touch),
    .touch_way (touch_way),
    .lru_way   (lru_way),
    .age       (age)
  );

  // Scanning downwards leaves the lowest matching/invalid index as the winner.
  always_comb begin
    match   = '0;
    hit_way = '0;
    inv_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      match[i] = valid[i] && (tags[i] == addr_q);
      if (match[i]) hit_way = AW'(i);
      if (!valid[i]) inv_way = AW'(i);
    end
  end

  assign any_hit   = |match;
  assign any_inv   = ~&valid;
  assign target    = any_inv ? inv_way : lru_way;
  assign tgt_dirty = valid[target] && dirty[target];
  assign fill_way  = (state == WRITEBACK) ? tgt_q : target;
  assign touch_way = merge ? hit_way : fill_way;

  always_comb begin
    state_nxt = state;
    touch     = 1'b0;
    fill      = 1'b0;
    merge     = 1'b0;
    take_hit  = 1'b0;
    to_wb     = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) state_nxt = COMPARE;
      COMPARE: begin
        state_nxt = RESP;
        if (op_q == VC_LOOKUP) begin
          take_hit = any_hit;
        end else if (any_hit) begin
          merge = 1'b1;
          touch = 1'b1;
        end else if (tgt_dirty) begin
          to_wb     = 1'b1;
          state_nxt = WRITEBACK;
        end else begin
          fill  = 1'b1;
          touch = 1'b1;
        end
      end
      WRITEBACK: if (bus.wb_ready) begin
        fill      = 1'b1;
        touch     = 1'b1;
        state_nxt = RESP;
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // take_hit/merge only fire on the COMPARE->RESP edge, so the response
  // registers are non-zero exactly during the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
      resp_dirty_q <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
    end else begin
      state        <= state_nxt;
      resp_hit_q   <= take_hit | merge;
      resp_data_q  <= take_hit ? lines[hit_way] : '0;
      resp_dirty_q <= take_hit && dirty[hit_way];
      if (take_hit) begin
        valid[hit_way] <= 1'b0;
        dirty[hit_way] <= 1'b0;
      end
      if (merge) dirty[hit_way] <= dirty[hit_way] | dirty_q;
      if (fill) begin
        valid[fill_way] <= 1'b1;
        dirty[fill_way] <= dirty_q;
      end
      if (to_wb) begin
        wb_addr_q <= tags[target];
        wb_data_q <= lines[target];
      end else if (state == WRITEBACK && bus.wb_ready) begin
        wb_addr_q <= '0;
        wb_data_q <= '0;
      end
    end
  end

  // Storage and the request latch carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      op_q    <= vc_op_e'(bus.req_op);
      addr_q  <= bus.req_address;
      data_q  <= bus.req_data;
      dirty_q <= bus.req_dirty;
    end
    if (to_wb) tgt_q <= target;
    if (merge) lines[hit_way] <= data_q;
    if (fill) begin
      tags[fill_way]  <= addr_q;
      lines[fill_way] <= data_q;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_dirty = resp_dirty_q;
  assign bus.wb_valid   = (state == WRITEBACK);
  assign bus.wb_address = wb_addr_q;
  assign bus.wb_data    = wb_data_q;

  lru_sane: assert property (@(posedge clk) disable iff (rst)
    age[lru_way] == AW'(NUM_WAYS - 1));
endmodule

// File: tb/tb_victim_cache_param.sv
// Random and directed stimulus checked cycle by cycle against a recency-list cache model.
module tb_victim_cache_param;
  localparam int NW = 8;
  localparam int AW = 12;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  victim_cache_param_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  victim_cache_param #(.NUM_WAYS(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: per-way contents plus a recency list, most recently filled first.
  bit            m_valid[NW];
  bit            m_dirty[NW];
  logic [AW-1:0] m_tag[NW];
  logic [DW-1:0] m_data[NW];
  int            rec[$];

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  logic          exp_ready, exp_rv, exp_rh, exp_rdt, exp_wbv;
  logic [DW-1:0] exp_rd, exp_wbd;
  logic [AW-1:0] exp_wba;

  logic          got_hit, got_dirty;
  logic [DW-1:0] got_data, got_wbd;
  logic [AW-1:0] got_wba;
  bit            last_wb;

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    rec.delete();
    for (int i = 0; i < NW; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      rec.push_back(i);
    end
  endfunction

  function automatic void model_touch(input int w);
    for (int i = 0; i < rec.size(); i++)
      if (rec[i] == w) begin
        rec.delete(i);
        break;
      end
    rec.push_front(w);
  endfunction

  function automatic void model_apply(input bit op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input bit dt, output bit hit, output logic [DW-1:0] rd,
                                      output bit rdt, output bit wb, output logic [AW-1:0] wba,
                                      output logic [DW-1:0] wbd);
    int h = -1;
    int t = -1;
    for (int i = 0; i < NW; i++) if (h < 0 && m_valid[i] && m_tag[i] == a) h = i;
    hit = (h >= 0); rd = '0; rdt = 0; wb = 0; wba = '0; wbd = '0;
    if (!op) begin
      if (hit) begin
        rd = m_data[h]; rdt = m_dirty[h];
        m_valid[h] = 0; m_dirty[h] = 0;
      end
    end else if (hit) begin
      m_data[h]  = d;
      m_dirty[h] = m_dirty[h] | dt;
      model_touch(h);
    end else begin
      for (int i = 0; i < NW; i++) if (t < 0 && !m_valid[i]) t = i;
      if (t < 0) t = rec[$];
      if (m_valid[t] && m_dirty[t]) begin
        wb = 1; wba = m_tag[t]; wbd = m_data[t];
      end
      m_tag[t] = a; m_data[t] = d; m_valid[t] = 1; m_dirty[t] = dt;
      model_touch(t);
    end
  endfunction

  task automatic set_busy_exp();
    exp_ready = 0; exp_rv = 0; exp_rh = 0; exp_rd = '0; exp_rdt = 0;
    exp_wbv = 0; exp_wba = '0; exp_wbd = '0;
  endtask

  task automatic set_idle_exp();
    set_busy_exp();
    exp_ready = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready",  DW'(bus.req_ready),  DW'(exp_ready));
      chk("resp_valid", DW'(bus.resp_valid), DW'(exp_rv));
      chk("resp_hit",   DW'(bus.resp_hit),   DW'(exp_rh));
      chk("resp_data",  bus.resp_data,       exp_rd);
      chk("resp_dirty", DW'(bus.resp_dirty), DW'(exp_rdt));
      chk("wb_valid",   DW'(bus.wb_valid),   DW'(exp_wbv));
      chk("wb_address", DW'(bus.wb_address), DW'(exp_wba));
      chk("wb_data",    bus.wb_data,         exp_wbd);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      bus.wb_ready = 1'($urandom);
      set_idle_exp();
      step();
    end
    bus.wb_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    set_idle_exp();
    step();
    model_reset();
    set_idle_exp();
    rst = 0;
  endtask

  // abort_at >= 0 asserts rst in that writeback cycle instead of completing.
  task automatic do_req(input bit op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit dt, input int hold, input int abort_at);
    bit hit, rdt, wb;
    logic [DW-1:0] rd, wbd;
    logic [AW-1:0] wba;
    bus.req_valid = 1; bus.req_op = op; bus.req_address = a; bus.req_data = d; bus.req_dirty = dt;
    set_idle_exp();
    step();
    bus.req_valid = 0; bus.req_op = 1'($urandom); bus.req_address = AW'($urandom);
    bus.req_data = rnd(); bus.req_dirty = 1'($urandom); bus.wb_ready = 1'($urandom);
    model_apply(op, a, d, dt, hit, rd, rdt, wb, wba, wbd);
    last_wb = wb;
    set_busy_exp();
    step();
    bus.wb_ready = 0;
    got_wba = '0; got_wbd = '0;
    if (wb) begin
      for (int c = 0; c < 200; c++) begin
        set_busy_exp();
        exp_wbv = 1; exp_wba = wba; exp_wbd = wbd;
        bus.wb_ready = (c >= hold);
        if (c == 0) begin
          @(negedge clk);
          got_wba = bus.wb_address; got_wbd = bus.wb_data;
        end
        if (c == abort_at) begin
          rst = 1;
          step();
          rst = 0;
          model_reset();
          set_idle_exp();
          return;
        end
        step();
        if (c >= hold) break;
      end
      bus.wb_ready = 0;
    end
    set_busy_exp();
    exp_rv = 1; exp_rh = hit; exp_rd = rd; exp_rdt = rdt;
    @(negedge clk);
    got_hit = bus.resp_hit; got_data = bus.resp_data; got_dirty = bus.resp_dirty;
    step();
    set_idle_exp();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] da, db, dc;
    da = rnd(); db = rnd(); dc = rnd();
    bus.req_valid = 0; bus.req_op = 0; bus.req_address = '0; bus.req_data = '0;
    bus.req_dirty = 0; bus.wb_ready = 0;
    rst = 1;
    step();
    model_reset();
    set_idle_exp();
    chk_en = 1;
    rst = 0;
    idle(2);

    do_req(0, 12'h123, rnd(), 0, 0, -1);
    chk("t1_miss_hit", DW'(got_hit), DW'(0));
    chk("t1_miss_data", got_data, '0);

    do_req(1, 12'h010, da, 0, 0, -1);
    do_req(0, 12'h010, rnd(), 0, 0, -1);
    chk("t2_hit", DW'(got_hit), DW'(1));
    chk("t2_data", got_data, da);
    chk("t2_dirty", DW'(got_dirty), DW'(0));
    do_req(0, 12'h010, rnd(), 0, 0, -1);
    chk("t2_second_miss", DW'(got_hit), DW'(0));

    do_reset();
    for (int i = 0; i < 8; i++) do_req(1, AW'(12'h100 + i), rnd(), 0, 0, -1);
    do_req(1, 12'h200, rnd(), 0, 0, -1);
    chk("t3_no_wb", DW'(last_wb), DW'(0));
    do_req(0, 12'h100, rnd(), 0, 0, -1);
    chk("t3_evicted", DW'(got_hit), DW'(0));
    do_req(0, 12'h101, rnd(), 0, 0, -1);
    chk("t3_kept", DW'(got_hit), DW'(1));

    do_reset();
    do_req(1, 12'h300, db, 1, 0, -1);
    for (int i = 1; i < 8; i++) do_req(1, AW'(12'h300 + i), rnd(), 0, 0, -1);
    do_req(1, 12'h400, rnd(), 0, 5, -1);
    chk("t4_wb_seen", DW'(last_wb), DW'(1));
    chk("t4_wb_addr", DW'(got_wba), DW'(12'h300));
    chk("t4_wb_data", got_wbd, db);

    do_req(1, 12'h050, rnd(), 0, 0, -1);
    do_req(1, 12'h050, dc, 1, 0, -1);
    chk("t5_merge_hit", DW'(got_hit), DW'(1));
    chk("t5_merge_no_wb", DW'(last_wb), DW'(0));
    do_req(0, 12'h050, rnd(), 0, 0, -1);
    chk("t5_data", got_data, dc);
    chk("t5_dirty", DW'(got_dirty), DW'(1));

    do_reset();
    for (int i = 0; i < 8; i++) do_req(1, AW'(12'h500 + i), rnd(), 1, 0, -1);
    do_req(1, 12'h600, rnd(), 0, 10, 2);
    idle(1);
    for (int i = 0; i < 8; i++) begin
      do_req(0, AW'(12'h500 + i), rnd(), 0, 0, -1);
      chk("t6_after_reset_miss", DW'(got_hit), DW'(0));
    end
    do_req(0, 12'h600, rnd(), 0, 0, -1);
    chk("t6_dropped_fill", DW'(got_hit), DW'(0));

    do_reset();
    for (int n = 0; n < 300; n++) begin
      do_req(1'($urandom), AW'($urandom_range(0, 13)), rnd(), 1'($urandom),
             $urandom_range(0, 3), -1);
      idle($urandom_range(0, 2));
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
